// File: rtl/wb_write_port.sv
// Writeback port merger: ALU results (no backpressure) and buffered load
// results share the register file's single write port. ALU writes win; loads
// drain from a small FIFO whenever the ALU is idle. A pending bitmap exposes
// live buffered load destinations so issue can stall on them.
module wb_write_port #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [DWIDTH-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [DWIDTH-1:0]        ld_data,
    output logic                     we,
    output logic [4:0]               rdst_id,
    output logic [DWIDTH-1:0]        rdst,
    output logic [31:0]              pend,
    output logic [$clog2(DEPTH):0]   buf_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_idx, rd_idx;

    logic [4:0]          ent_rd_q   [DEPTH];
    logic [DWIDTH-1:0]   ent_data_q [DEPTH];
    logic [DEPTH-1:0]    live_q, live_d;

    logic                we_q, we_d;
    logic [4:0]          rdst_id_q, rdst_id_d;
    logic [DWIDTH-1:0]   rdst_q, rdst_d;

    logic                empty, full;
    logic                alu_wr, push_hs, store, pop, same_rd;

    // Handshake and write-selection decode.
    always_comb begin
        wr_idx   = wr_ptr_q[AW-1:0];
        rd_idx   = rd_ptr_q[AW-1:0];
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
        // A full buffer refuses a push even if it pops this cycle.
        ld_ready = !full && !rst;
        alu_wr   = alu_valid && (alu_rd != 5'd0);
        push_hs  = ld_valid && ld_ready;
        store    = push_hs && (ld_rd != 5'd0);
        pop      = !alu_wr && !empty;
        // ALU result is younger than a load pushed in the same cycle.
        same_rd  = alu_wr && (ld_rd == alu_rd);
    end

    // Next-state for pointers, liveness and the registered write port.
    always_comb begin
        // NOTE: every output of this block is given a default first so that
        // no path leaves a value unassigned and a latch cannot be inferred.
        live_d    = live_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        we_d      = 1'b0;
        rdst_id_d = rdst_id_q;
        rdst_d    = rdst_q;

        if (alu_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd_q[i] == alu_rd) live_d[i] = 1'b0;
            end
            we_d      = 1'b1;
            rdst_id_d = alu_rd;
            rdst_d    = alu_data;
        end else if (pop) begin
            if (live_q[rd_idx]) begin
                we_d      = 1'b1;
                rdst_id_d = ent_rd_q[rd_idx];
                rdst_d    = ent_data_q[rd_idx];
            end
        end

        if (pop) begin
            live_d[rd_idx] = 1'b0;
            rd_ptr_d       = rd_ptr_q + (AW+1)'(1);
        end

        // Push and pop never share a slot: that needs full or empty.
        if (store) begin
            live_d[wr_idx] = !same_rd;
            wr_ptr_d       = wr_ptr_q + (AW+1)'(1);
        end
    end

    // Control state and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            live_q    <= '0;
            we_q      <= 1'b0;
            rdst_id_q <= '0;
            rdst_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            live_q    <= live_d;
            we_q      <= we_d;
            rdst_id_q <= rdst_id_d;
            rdst_q    <= rdst_d;
        end
    end

    // FIFO payload storage, written at the tail on a stored push.
    // NOTE: payload is not reset; live_q gates every use of it, so stale
    // contents are never observable and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (store) begin
            ent_rd_q[wr_idx]   <= ld_rd;
            ent_data_q[wr_idx] <= ld_data;
        end
    end

    // Pending bitmap: one-hot OR of live buffered destinations.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pend[ent_rd_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign we      = we_q;
    assign rdst_id = rdst_id_q;
    assign rdst    = rdst_q;
    assign buf_cnt = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_wb_write_port.sv
// Directed testbench for wb_write_port. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after the following rising edge.
module tb_wb_write_port;

    localparam int DWIDTH = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic [4:0]        alu_rd = '0;
    logic [DWIDTH-1:0] alu_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [4:0]        ld_rd = '0;
    logic [DWIDTH-1:0] ld_data = '0;
    logic              we;
    logic [4:0]        rdst_id;
    logic [DWIDTH-1:0] rdst;
    logic [31:0]       pend;
    logic [2:0]        buf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    wb_write_port #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .we(we), .rdst_id(rdst_id), .rdst(rdst),
        .pend(pend), .buf_cnt(buf_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL reset_we got %0b want 0", we); end
        n_checks++; if (rdst_id !== 5'd0) begin n_errors++; $display("FAIL reset_rdst_id got %0d want 0", rdst_id); end
        n_checks++; if (rdst !== '0) begin n_errors++; $display("FAIL reset_rdst got %h want 0", rdst); end
        n_checks++; if (pend !== 32'h0) begin n_errors++; $display("FAIL reset_pend got %h want 0", pend); end
        n_checks++; if (buf_cnt !== 3'd0) begin n_errors++; $display("FAIL reset_buf_cnt got %0d want 0", buf_cnt); end
        n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ld_ready got %0b want 0", ld_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ld_ready got %0b want 1", ld_ready); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5A5A5;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b1) begin n_errors++; $display("FAIL alu_we got %0b want 1", we); end
        n_checks++; if (rdst_id !== 5'd5) begin n_errors++; $display("FAIL alu_rdst_id got %0d want 5", rdst_id); end
        n_checks++; if (rdst !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL alu_rdst got %h want a5a5a5a5", rdst); end
        step();
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL alu_we_after got %0b want 0", we); end
        n_checks++; if (rdst_id !== 5'd5) begin n_errors++; $display("FAIL alu_id_hold got %0d want 5", rdst_id); end
    endtask

    task automatic test_backpressure();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        for (int k = 1; k <= 4; k++) begin
            ld_valid = 1'b1; ld_rd = 5'(k); ld_data = 32'(k * 'h11);
            step();
            n_checks++; if (we !== 1'b1 || rdst_id !== 5'd7) begin n_errors++; $display("FAIL bp_alu_only we=%0b id=%0d want we=1 id=7", we, rdst_id); end
        end
        ld_valid = 1'b0;
        #1;
        n_checks++; if (buf_cnt !== 3'd4) begin n_errors++; $display("FAIL bp_cnt_full got %0d want 4", buf_cnt); end
        n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_full got %0b want 0", ld_ready); end
        n_checks++; if (pend !== 32'h1E) begin n_errors++; $display("FAIL bp_pend got %h want 0000001e", pend); end
        alu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++; if (we !== 1'b1 || rdst_id !== 5'(k) || rdst !== 32'(k * 'h11))
                begin n_errors++; $display("FAIL bp_drain%0d we=%0b id=%0d data=%h want we=1 id=%0d data=%h", k, we, rdst_id, rdst, k, k * 'h11); end
            n_checks++; if (buf_cnt !== 3'(4 - k)) begin n_errors++; $display("FAIL bp_drain_cnt%0d got %0d want %0d", k, buf_cnt, 4 - k); end
            if (k == 1) begin
                n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_return got %0b want 1", ld_ready); end
            end
        end
        step();
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL bp_empty_we got %0b want 0", we); end
    endtask

    task automatic test_kill();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        step();
        idle_inputs();
        n_checks++; if (pend !== 32'h200) begin n_errors++; $display("FAIL kill_pend_set got %h want 00000200", pend); end
        n_checks++; if (buf_cnt !== 3'd1) begin n_errors++; $display("FAIL kill_cnt_set got %0d want 1", buf_cnt); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b1 || rdst_id !== 5'd9 || rdst !== 32'h1234)
            begin n_errors++; $display("FAIL kill_alu we=%0b id=%0d data=%h want we=1 id=9 data=00001234", we, rdst_id, rdst); end
        n_checks++; if (pend !== 32'h0) begin n_errors++; $display("FAIL kill_pend_clear got %h want 0", pend); end
        step();
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL kill_dead_pop_we got %0b want 0", we); end
        n_checks++; if (buf_cnt !== 3'd0) begin n_errors++; $display("FAIL kill_dead_pop_cnt got %0d want 0", buf_cnt); end
    endtask

    task automatic test_same_cycle_kill();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b1 || rdst_id !== 5'd3 || rdst !== 32'h3333)
            begin n_errors++; $display("FAIL same_alu we=%0b id=%0d data=%h want we=1 id=3 data=00003333", we, rdst_id, rdst); end
        n_checks++; if (buf_cnt !== 3'd1) begin n_errors++; $display("FAIL same_cnt got %0d want 1", buf_cnt); end
        n_checks++; if (pend !== 32'h0) begin n_errors++; $display("FAIL same_pend got %h want 0", pend); end
        step();
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL same_dead_pop_we got %0b want 0", we); end
        n_checks++; if (buf_cnt !== 3'd0) begin n_errors++; $display("FAIL same_dead_pop_cnt got %0d want 0", buf_cnt); end
    endtask

    task automatic test_x0();
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBAD0;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready got %0b want 1", ld_ready); end
        step();
        idle_inputs();
        n_checks++; if (buf_cnt !== 3'd0) begin n_errors++; $display("FAIL x0_ld_cnt got %0d want 0", buf_cnt); end
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL x0_ld_we got %0b want 0", we); end
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
        step();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b1 || rdst_id !== 5'd6 || rdst !== 32'h66)
            begin n_errors++; $display("FAIL x0_alu_pop we=%0b id=%0d data=%h want we=1 id=6 data=00000066", we, rdst_id, rdst); end
        n_checks++; if (buf_cnt !== 3'd0) begin n_errors++; $display("FAIL x0_alu_cnt got %0d want 0", buf_cnt); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        step();
        idle_inputs();
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL x0_alu_drop_we got %0b want 0", we); end
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_rd = 5'(10 + k); ld_data = 32'(k);
            step();
        end
        n_checks++; if (buf_cnt !== 3'd3) begin n_errors++; $display("FAIL mr_cnt_pre got %0d want 3", buf_cnt); end
        n_checks++; if (pend !== 32'h1C00) begin n_errors++; $display("FAIL mr_pend_pre got %h want 00001c00", pend); end
        ld_rd = 5'd13; ld_data = 32'h13;
        rst = 1'b1;
        #1;
        n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL mr_we got %0b want 0", we); end
        n_checks++; if (pend !== 32'h0) begin n_errors++; $display("FAIL mr_pend got %h want 0", pend); end
        n_checks++; if (buf_cnt !== 3'd0) begin n_errors++; $display("FAIL mr_cnt got %0d want 0", buf_cnt); end
        n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL mr_ready got %0b want 0", ld_ready); end
        idle_inputs();
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL mr_ready_release got %0b want 1", ld_ready); end
        step();
        n_checks++; if (we !== 1'b0 || buf_cnt !== 3'd0) begin n_errors++; $display("FAIL mr_after we=%0b cnt=%0d want we=0 cnt=0", we, buf_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_backpressure();
        test_kill();
        test_same_cycle_kill();
        test_x0();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
- Writer-side companion of the 32-entry register file. It merges two writeback producers into the register file's single write port (we / rdst_id / rdst).
  - ALU results: single-cycle, no backpressure.
  - Load results: valid/ready handshake, buffered in a small FIFO.
- Also exports a pending-register bitmap so the issue stage can stall on buffered-but-unwritten load destinations.

Parameters:
- DWIDTH, 32, data width; matches the register file.
- DEPTH, 4, load buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  system reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register ID
- alu_data  in  DWIDTH  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_rd  in  5  load destination register ID
- ld_data  in  DWIDTH  load data
- we  out  1  register file write enable
- rdst_id  out  5  register file destination ID
- rdst  out  DWIDTH  register file write data
- pend  out  32  bit r = 1 iff a live buffered load targets register r
- buf_cnt  out  $clog2(DEPTH)+1  occupied FIFO entries, live or dead

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - we=0, rdst_id=0, rdst=0, pend=0, buf_cnt=0; FIFO empty, all entries dead.
  - ld_ready=0 while rst is high.
- ld_ready = !full && !rst. The readiness decision ignores a same-cycle pop: a full buffer refuses a push even when it pops.
- Push (ld_valid && ld_ready):
  - ld_rd==0: handshake completes, data is discarded, nothing is stored.
  - Otherwise: the entry {rd, data, live=1} is written at the tail.
- Write selection each cycle, in priority order:
  1. alu_valid && alu_rd!=0 → ALU write.
  2. Else if FIFO non-empty → pop head. Live head → load write. Dead head → no write; the slot is still consumed.
  3. Else → no write.
- alu_valid with alu_rd==0 is dropped and does not block the FIFO.
- Output registering:
  - At the posedge after selection: we / rdst_id / rdst take the selected write. Latency is 1 cycle from the input sample to the register file write strobe.
  - With no write: we=0; rdst_id and rdst hold their last values.
- Ordering rule: an ALU result is younger than every load already buffered and younger than a load pushed in the same cycle.
  - On an ALU write to r, every buffered entry with rd==r is marked dead at that edge.
  - A same-cycle push with ld_rd==r is stored dead.
- pend is derived combinationally from the registered FIFO contents: OR over live entries of one-hot(rd). Bit 0 is always 0.
- buf_cnt: +1 on a stored push, -1 on a pop, unchanged on simultaneous push and pop.
- Pointers: head and tail wrap modulo DEPTH. The full/empty distinction uses one extra pointer bit.
- Reset asserted mid-operation: buffered entries are lost, outputs return to reset values immediately, and any handshake in progress is not completed.
- No combinational path from any input to we / rdst_id / rdst.

Test Plan:
1. Reset release; alu_valid=1, alu_rd=5, alu_data=0xA5A5A5A5 for one cycle → next cycle we=1, rdst_id=5, rdst=0xA5A5A5A5; the following cycle we=0.
2. Backpressure:
   - Stimulus: 4 loads pushed (rd=1..4, data=0x11..0x44) while alu_valid=1, alu_rd=7 is held continuously.
   - Required: buf_cnt reaches 4, ld_ready=0, pend=0x1E, we carries only rd 7.
   - Then drop alu_valid → writes rd 1,2,3,4 in order on consecutive cycles; ld_ready returns to 1 after the first pop.
3. Kill rule:
   - Stimulus: buffer load rd=9 data=0x99 (pend[9]=1), then ALU write rd=9 data=0x1234.
   - Required: we rd9=0x1234; pend[9]=0; the later pop of the dead entry gives we=0 and buf_cnt decrements.
4. Same-cycle kill: push ld_rd=3 with alu_rd=3 in the same cycle → ALU value written; the stored entry is dead; pend[3] stays 0; no later write to rd 3.
5. x0 handling:
   - ld_rd=0 → handshake completes, buf_cnt unchanged.
   - alu_rd=0 with a non-empty FIFO → a FIFO entry pops that cycle; no write to ID 0 ever appears.
6. Mid-operation reset: rst pulsed while buf_cnt=3 → we=0, pend=0, buf_cnt=0 without waiting for a clock edge; ld_ready=0 during rst and 1 after release.
